// File: rtl/clock_set_controller_if.sv
// Button and display bundle between the clock controller and the board glue.
// The master drives the debounced button pulses; the slave returns the time fields and status.
interface clock_set_controller_if;
  logic       btn_mode;
  logic       btn_inc;
  logic       btn_dec;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [1:0] mode;
  logic       blink;
  logic       sec_tick;

  modport master (
    output btn_mode, btn_inc, btn_dec,
    input  seconds, minutes, hours, mode, blink, sec_tick
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec,
    output seconds, minutes, hours, mode, blink, sec_tick
  );
endinterface

// File: rtl/clock_set_controller.sv
// Timekeeping counters with a 1 Hz prescaler and a RUN / SET_HR / SET_MIN edit FSM.
// state   | meaning
// RUN     | time advances once per CLK_HZ cycles, buttons other than mode ignored
// SET_HR  | time frozen, inc/dec edit hours with wrap
// SET_MIN | time frozen, inc/dec edit minutes with wrap; leaving restarts at hh:mm:00
module clock_set_controller #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  clock_set_controller_if.slave  bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hr_q, hr_d;
  logic          tick_q, tick_d;
  logic          blink_q, blink_d;

  logic presc_tc;
  logic inc_ev;
  logic dec_ev;

  always_comb begin
    presc_tc = (presc_q == PRESC_TC);
    // A mode press swallows any edit in the same cycle; inc+dec cancel.
    inc_ev   = bus.btn_inc & ~bus.btn_dec & ~bus.btn_mode;
    dec_ev   = bus.btn_dec & ~bus.btn_inc & ~bus.btn_mode;

    mode_d  = mode_q;
    presc_d = presc_tc ? '0 : presc_q + 1'b1;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    tick_d  = 1'b0;

    case (mode_q)
      RUN: begin
        if (bus.btn_mode) mode_d = SET_HR;
        if (presc_tc) begin
          tick_d = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d = 6'd0;
            if (min_q == 6'd59) begin
              min_d = 6'd0;
              hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end
      end
      SET_HR: begin
        if (bus.btn_mode) mode_d = SET_MIN;
        else if (inc_ev) hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
        else if (dec_ev) hr_d = (hr_q == 5'd0) ? 5'd23 : hr_q - 5'd1;
      end
      SET_MIN: begin
        if (bus.btn_mode) begin
          mode_d  = RUN;
          sec_d   = 6'd0;
          presc_d = '0;
        end
        else if (inc_ev) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
        else if (dec_ev) min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
      end
      default: mode_d = RUN;
    endcase

    // Registered copy of (mode != RUN) && (prescaler >= CLK_HZ/2).
    blink_d = (mode_d != RUN) && (presc_d >= PRESC_HALF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= RUN;
      presc_q <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= 5'd0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
    end
  end

  assign bus.seconds  = sec_q;
  assign bus.minutes  = min_q;
  assign bus.hours    = hr_q;
  assign bus.mode     = mode_q;
  assign bus.blink    = blink_q;
  assign bus.sec_tick = tick_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller at CLK_HZ = 10: a vector table for the main flow
// plus hand sequences for mode-change-on-terminal-count, blink phases and async reset.
module tb_clock_set_controller;

  logic clk;
  logic reset;

  clock_set_controller_if cs_if ();

  clock_set_controller #(.CLK_HZ(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (cs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic m;
    logic i;
    logic d;
    int   n;
    int   sec;
    int   min;
    int   hr;
    int   mode;
    int   blink;
    int   tick;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic m, input logic i, input logic d);
    cs_if.btn_mode = m;
    cs_if.btn_inc  = i;
    cs_if.btn_dec  = d;
    tick();
    cs_if.btn_mode = 1'b0;
    cs_if.btn_inc  = 1'b0;
    cs_if.btn_dec  = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int sec, input int min, input int hr,
                         input int mode, input int blink, input int tk);
    chk({tag, ".seconds"},  int'(cs_if.seconds),  sec);
    chk({tag, ".minutes"},  int'(cs_if.minutes),  min);
    chk({tag, ".hours"},    int'(cs_if.hours),    hr);
    chk({tag, ".mode"},     int'(cs_if.mode),     mode);
    chk({tag, ".blink"},    int'(cs_if.blink),    blink);
    chk({tag, ".sec_tick"}, int'(cs_if.sec_tick), tk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    // m i d  n    sec min hr mode blink tick     (edge count / prescaler after vector)
    vecs[0]  = '{0,0,0,   9,  0,  0, 0, 0, 0, 0}; // E9   P9
    vecs[1]  = '{0,0,0,   1,  1,  0, 0, 0, 0, 1}; // E10  first second
    vecs[2]  = '{0,0,0,   1,  1,  0, 0, 0, 0, 0}; // E11
    vecs[3]  = '{0,1,0,   1,  1,  0, 0, 0, 0, 0}; // E12  inc ignored in RUN
    vecs[4]  = '{0,0,0, 588,  0,  1, 0, 0, 0, 1}; // E600 minute carry
    vecs[5]  = '{1,0,0,   1,  0,  1, 0, 1, 0, 0}; // E601 P1 SET_HR
    vecs[6]  = '{0,0,1,   1,  0,  1,23, 1, 0, 0}; // E602 P2 hours 0->23
    vecs[7]  = '{0,1,0,   1,  0,  1, 0, 1, 0, 0}; // E603 P3
    vecs[8]  = '{0,1,0,   1,  0,  1, 1, 1, 0, 0}; // E604 P4
    vecs[9]  = '{0,1,1,   1,  0,  1, 1, 1, 1, 0}; // E605 P5 inc+dec cancel
    vecs[10] = '{0,0,1,   1,  0,  1, 0, 1, 1, 0}; // E606 P6
    vecs[11] = '{0,0,1,   1,  0,  1,23, 1, 1, 0}; // E607 P7
    vecs[12] = '{1,1,0,   1,  0,  1,23, 2, 1, 0}; // E608 P8 mode wins over inc
    vecs[13] = '{0,0,1,   1,  0,  0,23, 2, 1, 0}; // E609 P9
    vecs[14] = '{0,0,1,   1,  0, 59,23, 2, 0, 0}; // E610 P0 no tick while frozen
    vecs[15] = '{0,1,0,   1,  0,  0,23, 2, 0, 0}; // E611 P1 59->0, no hour carry
    vecs[16] = '{0,0,1,   1,  0, 59,23, 2, 0, 0}; // E612 P2
    vecs[17] = '{1,0,0,   1,  0, 59,23, 0, 0, 0}; // E613 RUN, prescaler cleared
    vecs[18] = '{0,0,0,   9,  0, 59,23, 0, 0, 0}; // E622 P9
    vecs[19] = '{0,0,0,   1,  1, 59,23, 0, 0, 1}; // E623 exactly 10 after exit
    vecs[20] = '{0,0,0, 589, 59, 59,23, 0, 0, 0}; // E1212 23:59:59
    vecs[21] = '{0,0,0,   1,  0,  0, 0, 0, 0, 1}; // E1213 full rollover

    reset          = 1'b1;
    cs_if.btn_mode = 1'b0;
    cs_if.btn_inc  = 1'b0;
    cs_if.btn_dec  = 1'b0;
    #20;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;

    for (int k = 0; k < 22; k++) begin
      pulse(vecs[k].m, vecs[k].i, vecs[k].d);
      repeat (vecs[k].n - 1) tick();
      chk_all($sformatf("vec%0d", k), vecs[k].sec, vecs[k].min, vecs[k].hr,
              vecs[k].mode, vecs[k].blink, vecs[k].tick);
    end

    // Terminal count in the same cycle as RUN->SET_HR still advances seconds.
    repeat (9) tick();
    chk_all("pre_tc", 0, 0, 0, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    chk_all("tc_mode", 1, 0, 0, 1, 0, 1);

    // Prescaler is now 0; blink follows it with 5 low / 5 high phases.
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("blink_hr%0d", c), int'(cs_if.blink), ((c % 10) >= 5) ? 1 : 0);
      chk($sformatf("tick_hr%0d", c), int'(cs_if.sec_tick), 0);
    end
    pulse(1'b1, 1'b0, 1'b0);
    chk("to_setmin.mode", int'(cs_if.mode), 2);
    pulse(1'b1, 1'b0, 1'b0);
    chk_all("exit_run", 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("blink_run%0d", c), int'(cs_if.blink), 0);
      chk($sformatf("sec_run%0d", c), int'(cs_if.seconds), (c == 10) ? 1 : 0);
    end

    // Build 12:34:00 in SET_MIN with back-to-back pulses, then reset between edges.
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (12) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (34) pulse(1'b0, 1'b1, 1'b0);
    chk_all("pre_reset", 0, 34, 12, 2, int'(cs_if.blink), 0);
    #2;
    reset         = 1'b1;
    cs_if.btn_inc = 1'b1;
    #2;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0);
    cs_if.btn_inc = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    chk_all("post_reset", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
